uart_tx_scheduler: RTL and testbench

//  Shares the single uart_tx byte channel between two requesters: the SPI-slave receive stream and a

---
 rtl/uart_sched_pkg.sv | 16 +
 rtl/msg_period_timer.sv | 55 +++++
 rtl/uart_tx_scheduler.sv | 131 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg
//   Shared constants for the UART transmit scheduler: FSM state encodings,
//   requester identifiers and the default beacon text.
package uart_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic REQ_SPI = 1'b0;
  localparam logic REQ_MSG = 1'b1;

  localparam int          DEFAULT_MSG_LEN   = 6;
  localparam logic [47:0] DEFAULT_MSG_BYTES = "Test\r\n";

endpackage

// File: rtl/msg_period_timer.sv
// msg_period_timer
//   Beacon period timer. Counts 0..MSG_PERIOD_CYCLES-1 while enabled; the
//   terminal count either queues a beacon (msg_pending) or, when one is
//   already queued or being sent, reports it as lost (msg_dropped).
// Ports
//   clk, rst      clock, synchronous active-high reset
//   msg_enable    1 = timer runs; 0 = counter held at 0 and pending cleared
//   clear         beacon granted this cycle, consume msg_pending
//   msg_busy      beacon currently being issued
//   msg_pending   beacon waiting for a grant
//   msg_dropped   1-cycle pulse, a tick was lost
module msg_period_timer #(
  parameter int MSG_PERIOD_CYCLES = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic msg_enable,
  input  logic clear,
  input  logic msg_busy,
  output logic msg_pending,
  output logic msg_dropped
);

  localparam int             CW = $clog2(MSG_PERIOD_CYCLES);
  localparam logic [CW-1:0] TC = CW'(MSG_PERIOD_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = msg_enable && (cnt == TC);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      msg_pending <= 1'b0;
      msg_dropped <= 1'b0;
    end else begin
      msg_dropped <= 1'b0;
      if (!msg_enable) begin
        cnt         <= '0;
        msg_pending <= 1'b0;
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (clear) msg_pending <= 1'b0;
        // A tick coinciding with a grant sees msg_pending still set, so it
        // is reported as a drop and the grant's clear still wins.
        if (tick) begin
          if (msg_pending || msg_busy) msg_dropped <= 1'b1;
          else                         msg_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin arbiter sharing the uart_tx byte channel between the SPI
//   receive stream and a periodic fixed-text beacon. A beacon is issued as an
//   atomic block; SPI bytes are never interleaved into it.
// Ports
//   clk, rst           clock, synchronous active-high reset
//   msg_enable         1 = beacon timer runs
//   spi_data_ready     spi_slave holds an unread byte
//   spi_received_data  that byte
//   spi_read_ack       1-cycle pulse, SPI byte consumed
//   uart_ready         uart_tx can accept a byte
//   start_uart         1-cycle enqueue pulse to uart_tx
//   uart_data          byte for uart_tx, valid with start_uart
//   msg_busy           beacon granted and not yet fully issued
//   msg_dropped        1-cycle pulse, a beacon tick was lost
//
// state | meaning
// IDLE  | waiting for uart_ready and a request; arbitrates
// HOLD  | one cycle after an issue, lets uart_ready fall
// DRAIN | waiting for uart_tx to accept the next byte
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int                   CLOCK_FREQUENCY   = 27000000,
  parameter int                   MSG_PERIOD_CYCLES = CLOCK_FREQUENCY / 100,
  parameter int                   MSG_LEN           = DEFAULT_MSG_LEN,
  parameter logic [8*MSG_LEN-1:0] MSG_BYTES         = DEFAULT_MSG_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_enable,
  input  logic       spi_data_ready,
  input  logic [7:0] spi_received_data,
  output logic       spi_read_ack,
  input  logic       uart_ready,
  output logic       start_uart,
  output logic [7:0] uart_data,
  output logic       msg_busy,
  output logic       msg_dropped
);

  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  logic [1:0] state;
  logic       cur_req;
  logic       last_grant;
  logic [3:0] idx;
  logic       msg_pending;
  logic       idle_ready;
  logic       grant_msg;
  logic       grant_spi;
  logic [7:0] msg_rom [16];

  // Byte k sits at the MSB end first, so the text reads in order.
  for (genvar g = 0; g < 16; g++) begin : g_rom
    if (g < MSG_LEN) begin : g_used
      assign msg_rom[g] = MSG_BYTES[8*(MSG_LEN-g)-1 -: 8];
    end else begin : g_unused
      assign msg_rom[g] = 8'h00;
    end
  end

  assign idle_ready = (state == ST_IDLE) && uart_ready;
  // On a tie the requester that did not win last time is served.
  assign grant_msg  = idle_ready && msg_pending &&
                      (!spi_data_ready || (last_grant == REQ_SPI));
  assign grant_spi  = idle_ready && spi_data_ready && !grant_msg;

  msg_period_timer #(
    .MSG_PERIOD_CYCLES (MSG_PERIOD_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .msg_enable  (msg_enable),
    .clear       (grant_msg),
    .msg_busy    (msg_busy),
    .msg_pending (msg_pending),
    .msg_dropped (msg_dropped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cur_req      <= REQ_SPI;
      last_grant   <= REQ_MSG;
      idx          <= 4'd0;
      start_uart   <= 1'b0;
      spi_read_ack <= 1'b0;
      uart_data    <= 8'h00;
      msg_busy     <= 1'b0;
    end else begin
      start_uart   <= 1'b0;
      spi_read_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_spi) begin
            start_uart   <= 1'b1;
            spi_read_ack <= 1'b1;
            uart_data    <= spi_received_data;
            cur_req      <= REQ_SPI;
            state        <= ST_HOLD;
          end else if (grant_msg) begin
            start_uart <= 1'b1;
            uart_data  <= msg_rom[0];
            idx        <= 4'd0;
            msg_busy   <= 1'b1;
            cur_req    <= REQ_MSG;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: state <= ST_DRAIN;
        ST_DRAIN: begin
          if (uart_ready) begin
            if ((cur_req == REQ_MSG) && (idx < LAST_IDX)) begin
              idx        <= idx + 4'd1;
              start_uart <= 1'b1;
              uart_data  <= msg_rom[idx + 4'd1];
              state      <= ST_HOLD;
            end else begin
              if (cur_req == REQ_MSG) msg_busy <= 1'b0;
              last_grant <= cur_req;
              state      <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//   Self-checking bench: uart_tx model (ready falls 1 cycle after start and
//   stays low 20 cycles), SPI source queue, directed sequences for the
//   multi-cycle corner cases and a randomized stream checked against a
//   transaction-level model of the arbitration rules.
module tb_uart_tx_scheduler;

  localparam int PERIOD = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       msg_enable = 1'b0;
  logic       spi_data_ready;
  logic [7:0] spi_received_data;
  logic       spi_read_ack;
  logic       uart_ready;
  logic       start_uart;
  logic [7:0] uart_data;
  logic       msg_busy;
  logic       msg_dropped;

  uart_tx_scheduler #(
    .MSG_PERIOD_CYCLES (PERIOD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .msg_enable        (msg_enable),
    .spi_data_ready    (spi_data_ready),
    .spi_received_data (spi_received_data),
    .spi_read_ack      (spi_read_ack),
    .uart_ready        (uart_ready),
    .start_uart        (start_uart),
    .uart_data         (uart_data),
    .msg_busy          (msg_busy),
    .msg_dropped       (msg_dropped)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model
  int   busy_cnt = 0;
  logic force_low = 1'b0;
  always @(posedge clk) begin
    if (start_uart) busy_cnt <= 20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_ready = (busy_cnt == 0) && !force_low;

  // SPI source
  logic [7:0] spi_q[$];
  logic [7:0] spi_exp[$];

  task automatic spi_update();
    spi_data_ready    = (spi_q.size() != 0);
    spi_received_data = (spi_q.size() != 0) ? spi_q[0] : 8'h00;
  endtask

  task automatic spi_push(input logic [7:0] b);
    spi_q.push_back(b);
    spi_exp.push_back(b);
    spi_update();
  endtask

  always begin
    @(posedge clk);
    #1;
    if (spi_read_ack && spi_q.size() != 0) begin
      void'(spi_q.pop_front());
      spi_update();
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: condition not met (cycle %0d)", nm, cyc);
  endtask

  // monitor: log every issued byte, check handshake rules
  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       busy;
    int         cyc;
  } ev_t;
  ev_t  evq[$];
  int   rd = 0;
  int   ndrop = 0;
  int   last_drop = -1;
  logic prev_start = 1'b0;
  logic prev_ready = 1'b0;

  always @(negedge clk) begin
    if (start_uart) begin
      check("no_back_to_back_start", prev_start, 1'b0);
      check("start_after_ready", prev_ready, 1'b1);
      check("ack_iff_spi_byte", spi_read_ack, !msg_busy);
      evq.push_back('{uart_data, spi_read_ack, msg_busy, cyc});
    end
    if (spi_read_ack) check("ack_only_with_start", start_uart, 1'b1);
    if (msg_dropped) begin
      ndrop++;
      last_drop = cyc;
    end
    prev_start = start_uart;
    prev_ready = uart_ready;
  end

  function automatic logic [7:0] msg_char(input int k);
    string s;
    s = "Test\r\n";
    return s[k];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic get_ev(output ev_t e, input int budget);
    int n;
    n = 0;
    while (evq.size() <= rd && n < budget) begin
      tick(1);
      n++;
    end
    if (evq.size() > rd) begin
      e = evq[rd];
      rd++;
    end else begin
      e = '{8'h00, 1'b0, 1'b0, -1};
      bad("start_uart_timeout");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    msg_enable = 1'b0;
    force_low = 1'b0;
    spi_q.delete();
    spi_exp.delete();
    spi_update();
    tick(25);
    rst = 1'b0;
    tick(2);
    rd = evq.size();
  endtask

  task automatic get_beacon(input string tag, input int off_at, output int first, output int last);
    ev_t e;
    first = -1;
    last = -1;
    for (int k = 0; k < 6; k++) begin
      get_ev(e, 400);
      check({tag, "_byte"}, e.data, msg_char(k));
      check({tag, "_no_ack"}, e.ack, 1'b0);
      check({tag, "_busy"}, e.busy, 1'b1);
      if (k == 0) first = e.cyc;
      if (k == off_at) msg_enable = 1'b0;
      last = e.cyc;
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_data;
    logic       exp_ack;
  } vec_t;
  vec_t vecs[5];

  initial begin
    ev_t e;
    int  c0, f1, l1, f2, l2, nd0, prev, r1, fl, n, blk, nb;

    vecs[0] = '{8'h55, 8'h55, 1'b1};
    vecs[1] = '{8'hAA, 8'hAA, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1};
    vecs[4] = '{8'h3C, 8'h3C, 1'b1};
    spi_update();

    // reset state
    tick(3);
    check("rst_start_uart", start_uart, 1'b0);
    check("rst_spi_read_ack", spi_read_ack, 1'b0);
    check("rst_uart_data", uart_data, 8'h00);
    check("rst_msg_busy", msg_busy, 1'b0);
    check("rst_msg_dropped", msg_dropped, 1'b0);

    // SPI only, beacon disabled
    do_reset();
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      spi_push(vecs[i].din);
      get_ev(e, 100);
      check("t1_data", e.data, vecs[i].exp_data);
      check("t1_ack", e.ack, vecs[i].exp_ack);
      if (i > 0) check("t1_gap_ge_22", (e.cyc - prev) >= 22, 1'b1);
      prev = e.cyc;
    end
    tick(30);
    check("t1_all_consumed", spi_q.size(), 0);
    check("t1_no_drop", ndrop, 0);

    // beacon only, two periods
    do_reset();
    nd0 = ndrop;
    c0 = cyc;
    msg_enable = 1'b1;
    get_beacon("t2a", -1, f1, l1);
    check("t2_first_latency", f1 - c0, 201);
    tick(l1 + 21 - cyc);
    check("t2_busy_until_drain", msg_busy, 1'b1);
    tick(1);
    check("t2_busy_cleared", msg_busy, 1'b0);
    get_beacon("t2b", -1, f2, l2);
    check("t2_period", f2 - f1, PERIOD);
    check("t2_no_drop", ndrop - nd0, 0);

    // SPI request during a beacon, then round-robin on the tie
    do_reset();
    msg_enable = 1'b1;
    tick(201);
    spi_push(8'h3C);
    get_beacon("t3a", -1, f1, l1);
    get_ev(e, 100);
    check("t3_spi_after_beacon", e.data, 8'h3C);
    check("t3_spi_ack", e.ack, 1'b1);
    void'(spi_exp.pop_front());
    for (int i = 0; i < 12; i++) spi_push(8'(8'h10 + i));
    n = 0;
    get_ev(e, 100);
    while (e.ack && n < 20) begin
      check("t3_spi_order", e.data, spi_exp.pop_front());
      n++;
      get_ev(e, 100);
    end
    check("t3_beacon2_first", e.data, 8'h54);
    check("t3_beacon2_not_starved", (e.cyc - f1) >= 200 && (e.cyc - f1) <= 225, 1'b1);
    check("t3_spi_between", n >= 1, 1'b1);
    for (int k = 1; k < 6; k++) begin
      get_ev(e, 100);
      check("t3_beacon2_byte", e.data, msg_char(k));
    end
    get_ev(e, 100);
    check("t3_spi_after_beacon2_ack", e.ack, 1'b1);
    check("t3_spi_after_beacon2_data", e.data, spi_exp[0]);

    // uart stalled for 500 cycles
    do_reset();
    nd0 = ndrop;
    c0 = cyc;
    msg_enable = 1'b1;
    force_low = 1'b1;
    tick(500);
    check("t4_drops_while_stalled", ndrop - nd0, 1);
    check("t4_drop_at_tick2", last_drop - c0, 400);
    check("t4_nothing_sent", evq.size() - rd, 0);
    force_low = 1'b0;
    get_beacon("t4", -1, f1, l1);
    check("t4_beacon_on_release", f1 - c0, 501);
    msg_enable = 1'b0;

    // reset mid-beacon
    do_reset();
    msg_enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      get_ev(e, 400);
      check("t5_pre_byte", e.data, msg_char(k));
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    r1 = cyc;
    @(negedge clk);
    check("t5_rst_start", start_uart, 1'b0);
    check("t5_rst_ack", spi_read_ack, 1'b0);
    check("t5_rst_data", uart_data, 8'h00);
    check("t5_rst_busy", msg_busy, 1'b0);
    get_ev(e, 400);
    check("t5_restart_byte", e.data, 8'h54);
    check("t5_restart_time", e.cyc - r1, 201);

    // msg_enable dropped mid-beacon
    do_reset();
    nd0 = ndrop;
    msg_enable = 1'b1;
    get_beacon("t6", 1, f1, l1);
    tick(600);
    check("t6_quiet_after", evq.size() - rd, 0);
    check("t6_no_drop", ndrop - nd0, 0);
    check("t6_busy_low", msg_busy, 1'b0);

    // randomized traffic against a transaction-level model
    do_reset();
    nd0 = ndrop;
    msg_enable = 1'b1;
    fl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29, 0) == 0) spi_push(8'($urandom));
      if (fl > 0) begin
        fl--;
        if (fl == 0) force_low = 1'b0;
      end else if ($urandom_range(149, 0) == 0) begin
        fl = $urandom_range(60, 1);
        force_low = 1'b1;
      end
      tick(1);
    end
    msg_enable = 1'b0;
    force_low = 1'b0;
    n = 0;
    while ((spi_q.size() != 0 || msg_busy) && n < 4000) begin
      tick(1);
      n++;
    end
    if (n >= 4000) bad("rnd_drain_timeout");
    tick(40);
    blk = 0;
    nb = 0;
    while (rd < evq.size()) begin
      e = evq[rd];
      rd++;
      if (e.ack) begin
        check("rnd_spi_not_inside_beacon", blk, 0);
        if (spi_exp.size() == 0) bad("rnd_spi_unexpected_byte");
        else check("rnd_spi_data", e.data, spi_exp.pop_front());
      end else begin
        check("rnd_beacon_byte", e.data, msg_char(blk));
        blk = (blk + 1) % 6;
        if (blk == 0) nb++;
      end
    end
    check("rnd_beacon_complete", blk, 0);
    check("rnd_spi_all_sent", spi_exp.size(), 0);
    check("rnd_ticks_accounted", (nb + ndrop - nd0) == 14 || (nb + ndrop - nd0) == 15, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
